// File: rtl/stream_array_pkg.sv
// Shared constants and types for the stream_array_mp memory slice.
package stream_array_pkg;

    localparam int unsigned W_DEF         = 32;
    localparam int unsigned AW_DEF        = 9;
    // Bit that flags "never written" inside the INIT value.
    localparam int unsigned INIT_FLAG_BIT = 31;

    // Read-port state: normal operation, or parked on an unwritten entry.
    typedef enum logic {
        PORT_RUN  = 1'b0,
        PORT_WAIT = 1'b1
    } port_state_e;

endpackage

// File: rtl/stream_array_rd_port.sv
// One read channel: a single-entry output slot fed by a latency-1 lookup.
// With STREAM_ARRAY_RAW_WAIT_EN defined, a read of an unwritten entry parks
// here and completes the cycle after a write to that entry fires.
module stream_array_rd_port
    import stream_array_pkg::*;
#(
    parameter int unsigned W  = W_DEF,
    parameter int unsigned AW = AW_DEF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [AW-1:0] ra,
    input  logic          ra_valid,
    output logic          ra_ready,
    output logic [W-1:0]  rd,
    output logic          rd_valid,
    input  logic          rd_ready,
    output logic [AW-1:0] look_addr_c,
`ifdef STREAM_ARRAY_RAW_WAIT_EN
    input  logic          look_hit,
`endif
    input  logic [W-1:0]  look_data
);

    logic [W-1:0] rd_q;
    logic [W-1:0] rd_d;
    logic         vld_q;
    logic         vld_d;
    logic         slot_free_c;

    assign slot_free_c = !vld_q || rd_ready;
    assign rd          = rd_q;
    assign rd_valid    = vld_q;

`ifdef STREAM_ARRAY_RAW_WAIT_EN
    port_state_e   state_q;
    port_state_e   state_d;
    logic [AW-1:0] pend_q;
    logic [AW-1:0] pend_d;

    // Wait-state and parked-address registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= PORT_RUN;
            pend_q  <= '0;
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
        end
    end

    // Accept, park on a miss, or complete a parked read when its entry is written.
    always_comb begin
        state_d     = state_q;
        pend_d      = pend_q;
        rd_d        = rd_q;
        vld_d       = vld_q && !rd_ready;
        ra_ready    = 1'b0;
        look_addr_c = ra;
        case (state_q)
            PORT_RUN: begin
                ra_ready = slot_free_c;
                if (ra_valid && slot_free_c) begin
                    if (look_hit) begin
                        rd_d  = look_data;
                        vld_d = 1'b1;
                    end else begin
                        pend_d  = ra;
                        state_d = PORT_WAIT;
                    end
                end
            end
            PORT_WAIT: begin
                look_addr_c = pend_q;
                if (look_hit) begin
                    rd_d    = look_data;
                    vld_d   = 1'b1;
                    state_d = PORT_RUN;
                end
            end
            default: state_d = PORT_RUN;
        endcase
    end
`else
    // Accept whenever the slot is empty or draining; unwritten entries return INIT.
    always_comb begin
        rd_d        = rd_q;
        vld_d       = vld_q && !rd_ready;
        ra_ready    = slot_free_c;
        look_addr_c = ra;
        if (ra_valid && slot_free_c) begin
            rd_d  = look_data;
            vld_d = 1'b1;
        end
    end
`endif

    // Output slot: data held stable until the consumer takes it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_q  <= '0;
            vld_q <= 1'b0;
        end else begin
            rd_q  <= rd_d;
            vld_q <= vld_d;
        end
    end

endmodule

// File: rtl/stream_array_mp.sv
// Multi-read-port stream-interfaced memory with per-entry written bits.
// Optional macro STREAM_ARRAY_RAW_WAIT_EN: reads of unwritten entries stall
// until written instead of returning INIT.
module stream_array_mp
    import stream_array_pkg::*;
#(
    parameter int unsigned  W    = W_DEF,
    parameter int unsigned  AW   = AW_DEF,
    parameter int unsigned  NR   = 2,
    parameter logic [W-1:0] INIT = W'(1) << INIT_FLAG_BIT
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            clr,
    input  logic [AW-1:0]   wa,
    input  logic            wa_valid,
    output logic            wa_ready,
    input  logic [W-1:0]    wd,
    input  logic            wd_valid,
    output logic            wd_ready,
    output logic            wb_valid,
    input  logic            wb_ready,
    input  logic [NR*AW-1:0] ra,
    input  logic [NR-1:0]   ra_valid,
    output logic [NR-1:0]   ra_ready,
    output logic [NR*W-1:0] rd,
    output logic [NR-1:0]   rd_valid,
    input  logic [NR-1:0]   rd_ready
);

    localparam int unsigned DEPTH = 1 << AW;

    logic [W-1:0]     mem [DEPTH];
    logic [DEPTH-1:0] written_q;
    logic [DEPTH-1:0] written_d;
    logic             wb_valid_q;
    logic             w_fire_c;

    // Address and data are taken together, only when the ack slot can accept.
    assign w_fire_c = wa_valid && wd_valid && (!wb_valid_q || wb_ready);
    assign wa_ready = w_fire_c;
    assign wd_ready = w_fire_c;
    assign wb_valid = wb_valid_q;

    // Write acknowledge: raised after each accepted write, held until taken.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wb_valid_q <= 1'b0;
        end else if (w_fire_c) begin
            wb_valid_q <= 1'b1;
        end else if (wb_ready) begin
            wb_valid_q <= 1'b0;
        end
    end

    // Written bits: clr wipes all, a same-cycle write still marks its entry.
    always_comb begin
        written_d = written_q;
        if (clr) begin
            written_d = '0;
        end
        if (w_fire_c) begin
            written_d[wa] = 1'b1;
        end
    end

    // Written-bit register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            written_q <= '0;
        end else begin
            written_q <= written_d;
        end
    end

    // Storage array; contents are meaningless until the written bit is set.
    always_ff @(posedge clk) begin
        if (w_fire_c) begin
            mem[wa] <= wd;
        end
    end

    // Per-channel lookup with write-first bypass, then the channel's slot.
    for (genvar k = 0; k < NR; k++) begin : g_rd
        logic [AW-1:0] look_addr_c;
        logic          bypass_c;
        logic [W-1:0]  look_data_c;

        assign bypass_c    = w_fire_c && (wa == look_addr_c);
        assign look_data_c = bypass_c ? wd
                           : (written_q[look_addr_c] ? mem[look_addr_c] : INIT);

`ifdef STREAM_ARRAY_RAW_WAIT_EN
        logic look_hit_c;
        assign look_hit_c = bypass_c || written_q[look_addr_c];
`endif

        stream_array_rd_port #(
            .W  (W),
            .AW (AW)
        ) u_port (
            .clk         (clk),
            .rst         (rst),
            .ra          (ra[k*AW +: AW]),
            .ra_valid    (ra_valid[k]),
            .ra_ready    (ra_ready[k]),
            .rd          (rd[k*W +: W]),
            .rd_valid    (rd_valid[k]),
            .rd_ready    (rd_ready[k]),
            .look_addr_c (look_addr_c),
`ifdef STREAM_ARRAY_RAW_WAIT_EN
            .look_hit    (look_hit_c),
`endif
            .look_data   (look_data_c)
        );
    end

endmodule

// File: tb/tb_stream_array_mp.sv
// Self-checking bench for stream_array_mp; follows STREAM_ARRAY_RAW_WAIT_EN.
module tb_stream_array_mp;

    localparam int unsigned W     = 32;
    localparam int unsigned AW    = 9;
    localparam int unsigned NR    = 2;
    localparam int unsigned DEPTH = 512;
    localparam logic [W-1:0] INIT = 32'h8000_0000;

    logic            clk = 1'b0;
    logic            rst;
    logic            clr;
    logic [AW-1:0]   wa;
    logic            wa_valid;
    logic            wa_ready;
    logic [W-1:0]    wd;
    logic            wd_valid;
    logic            wd_ready;
    logic            wb_valid;
    logic            wb_ready;
    logic [NR*AW-1:0] ra;
    logic [NR-1:0]   ra_valid;
    logic [NR-1:0]   ra_ready;
    logic [NR*W-1:0] rd;
    logic [NR-1:0]   rd_valid;
    logic [NR-1:0]   rd_ready;

    stream_array_mp dut (
        .clk      (clk),
        .rst      (rst),
        .clr      (clr),
        .wa       (wa),
        .wa_valid (wa_valid),
        .wa_ready (wa_ready),
        .wd       (wd),
        .wd_valid (wd_valid),
        .wd_ready (wd_ready),
        .wb_valid (wb_valid),
        .wb_ready (wb_ready),
        .ra       (ra),
        .ra_valid (ra_valid),
        .ra_ready (ra_ready),
        .rd       (rd),
        .rd_valid (rd_valid),
        .rd_ready (rd_ready)
    );

    always #5 clk = ~clk;

    // Reference model: memory image, written flags, ack slot, per-channel slot queues.
    int           checks = 0;
    int           errors = 0;
    int           acks   = 0;
    logic [W-1:0] m_mem [DEPTH];
    bit           m_wr  [DEPTH];
    bit           m_wb;
    logic [W-1:0] expq [NR][$];
    bit           pend_v [NR];
    logic [AW-1:0] pend_a [NR];
    bit           last_wfire;
    bit           last_rfire [NR];
    bit           rand_wb = 1'b0;
    bit           rand_rd = 1'b0;

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chkw(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic reset_model();
        for (int k = 0; k < NR; k++) begin
            expq[k].delete();
            pend_v[k] = 1'b0;
            last_rfire[k] = 1'b0;
        end
        foreach (m_wr[i]) m_wr[i] = 1'b0;
        m_wb = 1'b0;
    endtask

    // One clock: check outputs against the model mid-cycle, then advance the model.
    task automatic cyc();
        logic          exp_wr;
        logic          exp_rr;
        logic [AW-1:0] a;
        @(negedge clk);
        chk1("wb_valid", wb_valid, m_wb);
        exp_wr = wa_valid && wd_valid && (!m_wb || wb_ready);
        chk1("wa_ready", wa_ready, exp_wr);
        chk1("wd_ready", wd_ready, exp_wr);
        for (int k = 0; k < NR; k++) begin
            chk1("rd_valid", rd_valid[k], expq[k].size() != 0);
            if (expq[k].size() != 0) chkw("rd_data", rd[k*W +: W], expq[k][0]);
            exp_rr = !pend_v[k] && (expq[k].size() == 0 || rd_ready[k]);
            chk1("ra_ready", ra_ready[k], exp_rr);
            last_rfire[k] = ra_valid[k] && exp_rr;
        end
        last_wfire = exp_wr;
        if (wb_valid && wb_ready) acks++;
        if (m_wb && wb_ready) m_wb = 1'b0;
        if (exp_wr) m_wb = 1'b1;
        for (int k = 0; k < NR; k++) begin
            if (expq[k].size() != 0 && rd_ready[k]) void'(expq[k].pop_front());
            if (pend_v[k]) begin
                if (exp_wr && wa == pend_a[k]) begin
                    expq[k].push_back(wd);
                    pend_v[k] = 1'b0;
                end
            end else if (last_rfire[k]) begin
                a = ra[k*AW +: AW];
                if (exp_wr && wa == a) expq[k].push_back(wd);
                else if (m_wr[a]) expq[k].push_back(m_mem[a]);
`ifdef STREAM_ARRAY_RAW_WAIT_EN
                else begin
                    pend_v[k] = 1'b1;
                    pend_a[k] = a;
                end
`else
                else expq[k].push_back(INIT);
`endif
            end
        end
        if (clr) foreach (m_wr[i]) m_wr[i] = 1'b0;
        if (exp_wr) begin
            m_mem[wa] = wd;
            m_wr[wa]  = 1'b1;
        end
        @(posedge clk);
        #1;
        if (rand_wb) wb_ready = ($urandom_range(0, 3) != 0);
        if (rand_rd) for (int k = 0; k < NR; k++) rd_ready[k] = ($urandom_range(0, 3) != 0);
    endtask

    task automatic set_ra(input int k, input logic [AW-1:0] a);
        ra[k*AW +: AW] = a;
        ra_valid[k]    = 1'b1;
    endtask

    task automatic write_word(input logic [AW-1:0] a, input logic [W-1:0] d);
        bit fired = 1'b0;
        wa = a;
        wd = d;
        wa_valid = 1'b1;
        wd_valid = 1'b1;
        for (int i = 0; i < 50 && !fired; i++) begin
            cyc();
            fired = last_wfire;
        end
        wa_valid = 1'b0;
        wd_valid = 1'b0;
        chk1("write_fired", fired, 1'b1);
    endtask

    task automatic read_req(input int k, input logic [AW-1:0] a);
        bit fired = 1'b0;
        set_ra(k, a);
        for (int i = 0; i < 50 && !fired; i++) begin
            cyc();
            fired = last_rfire[k];
        end
        ra_valid[k] = 1'b0;
        chk1("read_fired", fired, 1'b1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int n [NR];
        int acks0;

        rst = 1'b1; clr = 1'b0;
        wa = '0; wd = '0; wa_valid = 1'b0; wd_valid = 1'b0; wb_ready = 1'b1;
        ra = '0; ra_valid = '0; rd_ready = '1;
        reset_model();
        repeat (2) @(posedge clk);
        #1;
        chk1("reset_wb_valid", wb_valid, 1'b0);
        chk1("reset_rd_valid0", rd_valid[0], 1'b0);
        chk1("reset_rd_valid1", rd_valid[1], 1'b0);
        chk1("reset_wa_ready", wa_ready, 1'b0);
        rst = 1'b0;
        cyc();

`ifndef STREAM_ARRAY_RAW_WAIT_EN
        // Unwritten read returns INIT at latency 1.
        read_req(0, 9'd5);
        chk1("req027_valid", rd_valid[0], 1'b1);
        chkw("req027_rd0", rd[W-1:0], INIT);
        cyc();
`else
        // Unwritten read stalls until its entry is written.
        read_req(0, 9'd7);
        repeat (20) cyc();
        chk1("req029_stall", rd_valid[0], 1'b0);
        write_word(9'd7, 32'd99);
        chk1("req029_valid", rd_valid[0], 1'b1);
        chkw("req029_rd", rd[W-1:0], 32'd99);
        cyc();
`endif

        // Fill 0..255 with data=addr, random gaps and ack back-pressure.
        acks0   = acks;
        rand_wb = 1'b1;
        for (int a = 0; a < 256; a++) begin
            repeat ($urandom_range(0, 2)) cyc();
            write_word(AW'(a), W'(a));
        end
        rand_wb  = 1'b0;
        wb_ready = 1'b1;
        cyc();
        chkw("req028_acks", W'(acks - acks0), W'(256));

        // Read back on both channels concurrently with random read back-pressure.
        rand_rd = 1'b1;
        for (int k = 0; k < NR; k++) n[k] = 0;
        for (int c = 0; c < 4000 && (n[0] < 256 || n[1] < 256); c++) begin
            for (int k = 0; k < NR; k++) begin
                if (n[k] < 256 && $urandom_range(0, 3) != 0) set_ra(k, AW'(n[k]));
                else ra_valid[k] = 1'b0;
            end
            cyc();
            for (int k = 0; k < NR; k++) if (last_rfire[k]) n[k]++;
        end
        ra_valid = '0;
        rand_rd  = 1'b0;
        rd_ready = '1;
        cyc();
        cyc();
        chk1("req028_all_read", (n[0] == 256) && (n[1] == 256), 1'b1);

        // Same-cycle write and read of one address, then a held output.
        rd_ready[0] = 1'b0;
        wa = 9'd3; wd = 32'd42; wa_valid = 1'b1; wd_valid = 1'b1;
        set_ra(0, 9'd3);
        cyc();
        chk1("req030_wfire", last_wfire, 1'b1);
        chk1("req030_rfire", last_rfire[0], 1'b1);
        wa_valid = 1'b0; wd_valid = 1'b0; ra_valid[0] = 1'b0;
        for (int i = 0; i < 5; i++) begin
            chk1("req030_hold_valid", rd_valid[0], 1'b1);
            chkw("req030_hold_rd", rd[W-1:0], 32'd42);
            cyc();
        end
        rd_ready[0] = 1'b1;
        cyc();

        // clr invalidates; a write coincident with clr survives it.
        write_word(9'd10, 32'h1234_5678);
        clr = 1'b1;
        cyc();
        clr = 1'b0;
`ifndef STREAM_ARRAY_RAW_WAIT_EN
        read_req(0, 9'd10);
        chkw("req031_clr_init", rd[W-1:0], INIT);
        cyc();
`endif
        clr = 1'b1;
        wa = 9'd11; wd = 32'd6; wa_valid = 1'b1; wd_valid = 1'b1;
        cyc();
        chk1("req031_wfire", last_wfire, 1'b1);
        clr = 1'b0; wa_valid = 1'b0; wd_valid = 1'b0;
        read_req(1, 9'd11);
        chkw("req031_rd11", rd[2*W-1:W], 32'd6);
        cyc();

        // Random mixed traffic on a small address window with occasional clr.
        rand_wb = 1'b1;
        rand_rd = 1'b1;
        for (int c = 0; c < 600; c++) begin
            wa_valid = 1'($urandom_range(0, 1));
            wd_valid = 1'($urandom_range(0, 1));
            wa       = AW'($urandom_range(0, 15));
            wd       = $urandom;
            clr      = ($urandom_range(0, 31) == 0);
            for (int k = 0; k < NR; k++) begin
                ra_valid[k]    = 1'($urandom_range(0, 1));
                ra[k*AW +: AW] = AW'($urandom_range(0, 15));
            end
            cyc();
        end
        wa_valid = 1'b0; wd_valid = 1'b0; clr = 1'b0; ra_valid = '0;
        rand_wb  = 1'b0; rand_rd = 1'b0;
        wb_ready = 1'b1; rd_ready = '1;
        repeat (3) cyc();

        // Reset mid-operation with an ack and a read result both pending.
        wb_ready    = 1'b0;
        rd_ready[0] = 1'b0;
        write_word(9'd20, 32'd77);
        read_req(0, 9'd20);
        chk1("req032_pre_wb", wb_valid, 1'b1);
        chk1("req032_pre_rd", rd_valid[0], 1'b1);
        rst = 1'b1;
        #1;
        chk1("req032_rd_valid", rd_valid[0], 1'b0);
        chk1("req032_wb_valid", wb_valid, 1'b0);
        reset_model();
        @(posedge clk);
        #1;
        rst = 1'b0;
        wb_ready = 1'b1;
        rd_ready = '1;
`ifndef STREAM_ARRAY_RAW_WAIT_EN
        read_req(0, 9'd0);
        chkw("req032_rd_init", rd[W-1:0], INIT);
        cyc();
`else
        read_req(0, 9'd0);
        repeat (3) cyc();
        chk1("req032_rd_stall", rd_valid[0], 1'b0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/stream_array_mp.md
STREAM_ARRAY_MP -- requirements
Module: stream_array_mp

Interface
REQ-001 SHALL have parameter W, default 32: data width in bits.
REQ-002 SHALL have parameter AW, default 9: address width; depth is 2**AW entries.
REQ-003 SHALL have parameter NR, default 2: number of independent read channels, 1..8.
REQ-004 SHALL have parameter INIT, default 1<<31: value returned for unwritten entries.
REQ-005 SHALL have port clk, input, 1: the single clock; all state changes on its rising edge.
REQ-006 SHALL have port rst, input, 1: asynchronous, active-high reset.
REQ-007 SHALL have port clr, input, 1: single-cycle pulse that invalidates all entries.
REQ-008 SHALL have ports wa / wa_valid / wa_ready, input / input / output, AW / 1 / 1: the write-address stream.
REQ-009 SHALL have ports wd / wd_valid / wd_ready, input / input / output, W / 1 / 1: the write-data stream.
REQ-010 SHALL have ports wb_valid / wb_ready, output / input, 1 / 1: the write-acknowledge null stream.
REQ-011 SHALL have ports ra / ra_valid / ra_ready, input / input / output, NR*AW / NR / NR: the read-address streams, one per channel.
REQ-012 SHALL have ports rd / rd_valid / rd_ready, output / output / input, NR*W / NR / NR: the read-data streams, one per channel.

Function
REQ-013 SHALL accept a write only when wa_valid, wd_valid and the ack slot are all free-or-draining (wb_valid=0 or wb_ready=1); wa_ready and wd_ready assert together.
REQ-014 SHALL raise wb_valid one cycle after the write fires and hold it until wb_ready.
REQ-015 SHALL keep one written bit per entry: set on write, cleared by clr.
REQ-016 SHALL set ra_ready[k] when rd slot k is empty or rd_ready[k]=1; an address fires on ra_valid[k]&&ra_ready[k].
REQ-017 SHALL present rd[k] with rd_valid[k] one cycle after the address fires (latency 1), held stable until rd_ready[k].
REQ-018 SHALL operate channels independently; NR reads and one write may fire in the same cycle.
REQ-019 SHALL return the new data when a read fires in the same cycle as a write to the same address (write-first).
REQ-020 SHALL let a write win over clr to the same address in the same cycle; that entry stays written.
REQ-021 SHALL wrap addresses modulo 2**AW and use no out-of-range state.

Reset
REQ-022 SHALL, on rst, clear within the same cycle: all written bits, wb_valid=0, rd_valid=0, and all rd slots.
REQ-023 SHALL discard in-flight reads and pending acks when rst rises mid-operation; memory contents are undefined until rewritten.

Configuration
REQ-024 SHALL provide macro STREAM_ARRAY_RAW_WAIT_EN.
- Defined: a read of an unwritten entry stalls (rd_valid stays 0, ra_ready stays 0) until that entry is written; the data then appears the cycle after the write fires.
- Undefined: a read of an unwritten entry completes at normal latency with rd=INIT.

Structure
REQ-025 SHALL take its stream macros and the W/AW defaults from the shared primitives header; INIT's invalid-flag bit position is a shared constant there.
REQ-026 SHALL instantiate NR copies of sub-module stream_array_rd_port, each holding one output slot plus its RAW-wait logic.

Verification
REQ-027 Reset, then read addr 5 on ch0 (macro off) -> rd0=0x80000000 one cycle later.
REQ-028 Write addr 0..255 with data=addr and random valid gaps; read back on ch0 and ch1 concurrently -> each returns rd=addr; 256 acks seen.
REQ-029 Macro on: issue read addr 7, write 7<-99 twenty cycles later -> rd_valid rises the cycle after the write, rd=99.
REQ-030 Same-cycle write 3<-42 and read 3 -> rd=42; hold rd_ready=0 for 5 cycles -> rd and rd_valid stable.
REQ-031 Write addr 10, pulse clr, read 10 (macro off) -> INIT; clr coincident with write 11<-6 -> read 11 returns 6.
REQ-032 Assert rst with a read and an ack pending -> rd_valid=0 and wb_valid=0 immediately; a post-reset read of addr 0 returns INIT.
